// File: rtl/bus_master_pkg.sv
// Shared types and constants for the bus master and the arbiter it talks to.
// No logic here, so there is no latency.
// No flow control here; this package only holds types and constants.
package bus_master_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;

    // Encoding of the rw bit, shared with the arbiter side of the bus
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RD_WAIT = 2'd2,
        RSP     = 2'd3
    } state_t;

    // One queued command: {rw, address, data}
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    function automatic logic is_write(input cmd_t c);
        return c.rw == RW_WRITE;
    endfunction

endpackage

// File: rtl/bus_master_if.sv
// Core command/response and shared-bus signals of one bus master.
// Wires only; the interface adds no latency.
// Backpressure is carried by cmd_ready on the command side and bus_grant on the bus side.
interface bus_master_if;
    import bus_master_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              bus_request;
    logic              bus_grant;
    logic [ADDR_W-1:0] bus_address;
    logic [DATA_W-1:0] bus_data_out;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_data_in;

    modport master (
        input  cmd_valid, cmd_rw, cmd_address, cmd_data, bus_grant, bus_data_in,
        output cmd_ready, rsp_valid, rsp_data, bus_request, bus_address, bus_data_out, bus_rw
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_address, cmd_data, bus_grant, bus_data_in,
        input  cmd_ready, rsp_valid, rsp_data, bus_request, bus_address, bus_data_out, bus_rw
    );

endinterface

// File: rtl/bus_master_cmd_fifo.sv
// Generic synchronous FIFO holding queued commands; the head is visible combinationally.
// A push becomes visible at the head one edge later; a pop takes effect at the edge.
// full blocks pushes unless a pop happens in the same cycle; pops on empty are ignored.
module cmd_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only used while count is non-zero
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/bus_master.sv
// Queues core read/write commands and issues them in order on a request/grant RAM bus.
// Request rises the cycle after a push into an idle queue; read data returns READ_LATENCY+1 cycles after grant.
// cmd_ready drops while the queue is full; bus outputs hold steady until bus_grant is seen.
module bus_master
    import bus_master_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    bus_master_if.master bm
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_t            state;
    state_t            state_nxt;
    cmd_t              push_cmd;
    cmd_t              head_cmd;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              push;
    logic              pop;
    logic              lat_done;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] rsp_data_q;

    // Gating with reset keeps cmd_ready low while reset is held, high right after release
    assign bm.cmd_ready = reset & ~fifo_full;
    assign push         = bm.cmd_valid & bm.cmd_ready;
    assign pop          = (state == REQ) & bm.bus_grant;
    assign push_cmd     = '{rw: bm.cmd_rw, address: bm.cmd_address, data: bm.cmd_data};
    assign lat_done     = (lat_cnt == LAT_W'(READ_LATENCY - 1));
    assign bm.rsp_data  = rsp_data_q;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_cmd),
        .pop      (pop),
        .head_dat (head_cmd),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: a write grant keeps requesting if anything remains queued after the pop
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = REQ;
            REQ: begin
                if (bm.bus_grant) begin
                    if (!is_write(head_cmd))                        state_nxt = RD_WAIT;
                    else if ((fifo_count > CNT_W'(1)) || push)      state_nxt = REQ;
                    else                                            state_nxt = IDLE;
                end
            end
            RD_WAIT: if (lat_done) state_nxt = RSP;
            RSP:     state_nxt = fifo_empty ? IDLE : REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: bus fields come straight from the queue head only while requesting
    always_comb begin
        bm.bus_request  = 1'b0;
        bm.bus_address  = '0;
        bm.bus_data_out = '0;
        bm.bus_rw       = RW_READ;
        bm.rsp_valid    = 1'b0;
        if (state == REQ) begin
            bm.bus_request  = 1'b1;
            bm.bus_address  = head_cmd.address;
            bm.bus_data_out = head_cmd.data;
            bm.bus_rw       = head_cmd.rw;
        end
        if (state == RSP) bm.rsp_valid = 1'b1;
    end

    // Read latency counter and response capture on the last wait cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_cnt    <= '0;
            rsp_data_q <= '0;
        end else begin
            if ((state == RD_WAIT) && !lat_done) lat_cnt <= lat_cnt + LAT_W'(1);
            else                                 lat_cnt <= '0;
            if ((state == RD_WAIT) && lat_done)  rsp_data_q <= bm.bus_data_in;
        end
    end

endmodule

// File: tb/tb_bus_master.sv
// Scoreboard bench for bus_master: commands are queued as expected bus cycles, read data as expected responses.
// A RAM model answers reads exactly TB_LAT cycles after grant and drives filler data otherwise.
// A grant driver answers bus_request after a programmable delay.
module tb_bus_master;
    import bus_master_pkg::*;

    localparam int TB_DEPTH = 2;
    localparam int TB_LAT   = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    bus_master_if bm_if();

    bus_master #(
        .FIFO_DEPTH   (TB_DEPTH),
        .READ_LATENCY (TB_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bm    (bm_if.master)
    );

    always #5 clk = ~clk;

    int          n_checks     = 0;
    int          n_errors     = 0;
    cmd_t        sb[$];
    logic [7:0]  rsp_q[$];
    int          n_grants     = 0;
    int          n_rsp        = 0;
    int          n_req_falls  = 0;
    int          req_len      = 0;
    int          last_req_len = 0;
    logic        grant_en     = 1'b0;
    int          grant_delay  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ram_val(input logic [8:0] a);
        return a[7:0] ^ 8'h6E;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic rw, input logic [8:0] a, input logic [7:0] d);
        cmd_t c;
        bit   ok;
        ok = 1'b0;
        c.rw = rw; c.address = a; c.data = d;
        bm_if.cmd_valid   = 1'b1;
        bm_if.cmd_rw      = rw;
        bm_if.cmd_address = a;
        bm_if.cmd_data    = d;
        for (int i = 0; i < 50; i++) begin
            if (bm_if.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check_eq("push_accept", 32'(ok), 1);
        if (ok) begin
            @(posedge clk);
            sb.push_back(c);
            #1;
        end
        bm_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (sb.size() == 0 && rsp_q.size() == 0 && !bm_if.bus_request) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check_eq("drain", 32'(done), 1);
        tick();
        tick();
    endtask

    // Grant driver: grant once bus_request has been seen for grant_delay cycles
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bm_if.bus_grant = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (grant_en && reset && bm_if.bus_request) begin
                if (wait_cnt >= grant_delay) begin
                    bm_if.bus_grant = 1'b1;
                    wait_cnt = 0;
                end else begin
                    bm_if.bus_grant = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bm_if.bus_grant = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // RAM model: read data valid only in the cycle TB_LAT after the grant cycle
    initial begin
        logic       pend [TB_LAT+1];
        logic [8:0] paddr[TB_LAT+1];
        for (int i = 0; i <= TB_LAT; i++) begin
            pend[i] = 1'b0;
            paddr[i] = '0;
        end
        bm_if.bus_data_in = 8'hC3;
        forever begin
            @(negedge clk);
            for (int i = TB_LAT; i > 0; i--) begin
                pend[i]  = pend[i-1];
                paddr[i] = paddr[i-1];
            end
            pend[0]  = reset && bm_if.bus_request && bm_if.bus_grant && (bm_if.bus_rw == RW_READ);
            paddr[0] = bm_if.bus_address;
            bm_if.bus_data_in = pend[TB_LAT] ? ram_val(paddr[TB_LAT]) : 8'hC3;
        end
    end

    // Monitor: bus cycles against the command scoreboard, responses against expected read data
    initial begin
        cmd_t cur;
        cmd_t prev_cmd;
        cmd_t exp_cmd;
        logic prev_wait;
        prev_wait = 1'b0;
        prev_cmd  = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_wait = 1'b0;
                req_len   = 0;
            end else begin
                cur.rw      = bm_if.bus_rw;
                cur.address = bm_if.bus_address;
                cur.data    = bm_if.bus_data_out;
                if (bm_if.bus_request) begin
                    req_len++;
                end else begin
                    if (req_len != 0) begin
                        last_req_len = req_len;
                        n_req_falls++;
                    end
                    req_len = 0;
                    check_eq("rw_idle", 32'(bm_if.bus_rw), 0);
                end
                if (prev_wait) begin
                    check_eq("req_hold", 32'(bm_if.bus_request), 1);
                    check_eq("cmd_hold", 32'(cur), 32'(prev_cmd));
                end
                prev_wait = bm_if.bus_request && !bm_if.bus_grant;
                prev_cmd  = cur;
                if (bm_if.bus_request && bm_if.bus_grant) begin
                    n_grants++;
                    check_eq("grant_expected", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        exp_cmd = sb.pop_front();
                        check_eq("bus_cmd", 32'(cur), 32'(exp_cmd));
                        if (exp_cmd.rw == RW_READ) rsp_q.push_back(ram_val(exp_cmd.address));
                    end
                end
                if (bm_if.rsp_valid) begin
                    n_rsp++;
                    check_eq("rsp_expected", 32'(rsp_q.size() != 0), 1);
                    if (rsp_q.size() != 0) check_eq("rsp_data", 32'(bm_if.rsp_data), 32'(rsp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, f0, g0;
        bit seen;
        bm_if.cmd_valid   = 1'b0;
        bm_if.cmd_rw      = 1'b0;
        bm_if.cmd_address = '0;
        bm_if.cmd_data    = '0;

        // Reset state: everything low, cmd_ready included
        #3;
        check_eq("rst_cmd_ready",   32'(bm_if.cmd_ready),    0);
        check_eq("rst_rsp_valid",   32'(bm_if.rsp_valid),    0);
        check_eq("rst_rsp_data",    32'(bm_if.rsp_data),     0);
        check_eq("rst_bus_request", 32'(bm_if.bus_request),  0);
        check_eq("rst_bus_address", 32'(bm_if.bus_address),  0);
        check_eq("rst_bus_data",    32'(bm_if.bus_data_out), 0);
        check_eq("rst_bus_rw",      32'(bm_if.bus_rw),       0);
        #19;
        reset = 1'b1;
        #1;
        check_eq("ready_after_release", 32'(bm_if.cmd_ready), 1);
        tick();

        // Single write, grant three cycles after request: request held four cycles
        grant_en = 1'b1;
        grant_delay = 3;
        push_cmd(RW_WRITE, 9'h1A5, 8'h3C);
        wait_idle(40);
        check_eq("wr_req_len", 32'(last_req_len), 4);
        check_eq("wr_queue_empty", 32'(bm_if.cmd_ready), 1);

        // Single read of 0x010: RAM returns 0x7E two cycles after grant
        grant_delay = 1;
        r0 = n_rsp;
        push_cmd(RW_READ, 9'h010, 8'h00);
        wait_idle(40);
        check_eq("rd_rsp_count", 32'(n_rsp - r0), 1);
        check_eq("rd_rsp_held", 32'(bm_if.rsp_data), 32'h7E);

        // Back-to-back writes: one continuous request for both
        grant_en = 1'b0;
        f0 = n_req_falls;
        push_cmd(RW_WRITE, 9'h101, 8'hA1);
        push_cmd(RW_WRITE, 9'h0F2, 8'hB2);
        tick();
        tick();
        check_eq("b2b_req_waiting", 32'(bm_if.bus_request), 1);
        grant_delay = 0;
        grant_en = 1'b1;
        wait_idle(40);
        check_eq("b2b_one_request", 32'(n_req_falls - f0), 1);

        // Full queue: third command waits until the first grant pops the head
        grant_en = 1'b0;
        push_cmd(RW_WRITE, 9'h0AA, 8'h11);
        push_cmd(RW_READ,  9'h0B0, 8'h22);
        check_eq("full_ready", 32'(bm_if.cmd_ready), 0);
        tick();
        tick();
        check_eq("full_ready_hold", 32'(bm_if.cmd_ready), 0);
        g0 = n_grants;
        grant_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n_grants != g0) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("full_first_grant", 32'(seen), 1);
        tick();
        check_eq("ready_after_pop", 32'(bm_if.cmd_ready), 1);
        push_cmd(RW_WRITE, 9'h155, 8'h99);
        wait_idle(60);

        // Reset during RD_WAIT: outputs drop at once, read is abandoned
        grant_delay = 0;
        push_cmd(RW_READ, 9'h1F0, 8'h00);
        g0 = n_grants;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n_grants != g0) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("rdrst_grant", 32'(seen), 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        sb.delete();
        rsp_q.delete();
        #1;
        check_eq("mid_cmd_ready",   32'(bm_if.cmd_ready),    0);
        check_eq("mid_rsp_valid",   32'(bm_if.rsp_valid),    0);
        check_eq("mid_rsp_data",    32'(bm_if.rsp_data),     0);
        check_eq("mid_bus_request", 32'(bm_if.bus_request),  0);
        check_eq("mid_bus_address", 32'(bm_if.bus_address),  0);
        check_eq("mid_bus_data",    32'(bm_if.bus_data_out), 0);
        check_eq("mid_bus_rw",      32'(bm_if.bus_rw),       0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("mid_ready_release", 32'(bm_if.cmd_ready), 1);
        r0 = n_rsp;
        repeat (8) tick();
        check_eq("mid_no_rsp", 32'(n_rsp - r0), 0);
        check_eq("mid_rsp_data_after", 32'(bm_if.rsp_data), 0);
        check_eq("mid_ready_edge", 32'(bm_if.cmd_ready), 1);
        push_cmd(RW_WRITE, 9'h033, 8'h44);
        wait_idle(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2: command queue entries, power of two, minimum 2.
REQ-002 The block SHALL have parameter READ_LATENCY, default 2: cycles from the grant cycle to the cycle in which bus_data_in is sampled, minimum 1.
REQ-003 The block SHALL use one clock, clk; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: the core offers a command.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: the queue accepts the command.
REQ-008 The block SHALL have port cmd_rw, input, 1 bit: 1 is a write, 0 is a read.
REQ-009 The block SHALL have port cmd_address, input, 9 bits: RAM address.
REQ-010 The block SHALL have port cmd_data, input, 8 bits: write data.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: one-cycle pulse marking read data.
REQ-012 The block SHALL have port rsp_data, output, 8 bits: read data, held until the next rsp_valid.
REQ-013 The block SHALL have port bus_request, output, 1 bit: request to the arbiter.
REQ-014 The block SHALL have port bus_grant, input, 1 bit: one-cycle grant from the arbiter.
REQ-015 The block SHALL have ports bus_address (output, 9 bits), bus_data_out (output, 8 bits), bus_rw (output, 1 bit) and bus_data_in (input, 8 bits).

Function
REQ-016 A command SHALL be accepted on a clk edge where cmd_valid and cmd_ready are both 1.
REQ-017 cmd_ready SHALL be 1 exactly when the queue is not full, independent of cmd_valid.
REQ-018 Commands SHALL be issued to the bus strictly in acceptance order.
- Reads and writes share one queue.
- There is no reordering and no forwarding.
REQ-019 The FSM SHALL have exactly four states.
- IDLE: go to REQ when the queue is non-empty.
- REQ: go to RD_WAIT on a grant for a read, or complete the write on a grant for a write.
- RD_WAIT: count READ_LATENCY cycles.
- RSP: one cycle, pulse rsp_valid, then go to IDLE or REQ.
REQ-020 In REQ, the outputs SHALL be driven as follows.
- bus_request = 1.
- bus_address, bus_rw and bus_data_out come from the queue head.
- All four SHALL be held stable until the cycle in which bus_grant is sampled 1.
REQ-021 A write SHALL complete in its grant cycle.
- The head is popped.
- If the queue still holds a command after the pop, the FSM stays in REQ with bus_request continuously 1.
- Otherwise it goes to IDLE.
REQ-022 A read grant SHALL pop the head, drop bus_request the next cycle, and sample bus_data_in exactly READ_LATENCY cycles after the grant cycle.
- The sampled value goes to rsp_data with rsp_valid = 1 for one cycle.
REQ-023 bus_request SHALL be 0 in IDLE, RD_WAIT and RSP.
- In those states bus_grant SHALL be ignored.
REQ-024 bus_rw SHALL be 0 whenever bus_request is 0.
REQ-025 Push and pop in the same cycle SHALL both take effect.
- Occupancy is unchanged.
- A full queue still accepts a push if cmd_ready was 1 at that edge.
REQ-026 Queue pointers SHALL wrap modulo FIFO_DEPTH.
- Occupancy is held in a counter of width log2(FIFO_DEPTH)+1 bits.
- Occupancy never exceeds FIFO_DEPTH.
- There is no underflow.
REQ-027 A command pushed into an empty queue SHALL raise bus_request no earlier than the next clock cycle (IDLE to REQ).

Reset
REQ-028 While reset is 0, all outputs SHALL be 0 asynchronously.
- FSM = IDLE.
- Queue empty.
- Latency counter 0.
- cmd_ready = 0 during reset.
- cmd_ready = 1 on the first edge after release.
REQ-029 Reset asserted mid-transaction SHALL abandon it.
- Any pending read produces no rsp_valid.
- Queued commands are discarded.

Structure
REQ-030 A shared package SHALL hold:
- the state enum (IDLE, REQ, RD_WAIT, RSP);
- ADDR_W = 9 and DATA_W = 8;
- the RW_READ = 0 and RW_WRITE = 1 constants, shared with the arbiter.
REQ-031 The queue SHALL be one sub-module, cmd_fifo, storing {rw, address, data} (18 bits).
- Its full and empty outputs drive cmd_ready and the FSM.

Verification
REQ-032 Single write: push write 0x1A5 (address) / 0x3C (data), grant 3 cycles after the request.
- Required: bus_request held for 4 cycles, address 0x1A5, data 0x3C, bus_rw = 1.
- Required: queue empty, then IDLE.
REQ-033 Single read: push read 0x010, grant; RAM drives 0x7E on bus_data_in 2 cycles after the grant.
- Required: rsp_valid pulses once with rsp_data = 0x7E.
REQ-034 Back-to-back writes: 2 writes queued, grants on consecutive opportunities.
- Required: bus_request never drops between them; issue order preserved.
REQ-035 Full queue: push 3 commands with grant held 0.
- Required: cmd_ready = 0 after 2 commands; the third is accepted in the cycle the first grant pops the head.
REQ-036 Reset mid-read: assert reset during RD_WAIT.
- Required: all outputs 0 immediately; no rsp_valid after release.
- Required: cmd_ready = 1 on the first edge after release.
